// File: rtl/sr_pix_pkg.sv
// rtl/sr_pix_pkg.sv - shared pixel geometry, counter widths and RGB pixel type
package sr_pix_pkg;

  localparam int PIX_WIDTH    = 24;
  localparam int LINE_WIDTH   = 960;
  localparam int FRAME_HEIGHT = 540;

  // Counter width for a modulo-n counter; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W = cnt_width(LINE_WIDTH);
  localparam int ROW_W = cnt_width(FRAME_HEIGHT);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pix_t;

endpackage

// File: rtl/fifo_axis_drain_if.sv
// rtl/fifo_axis_drain_if.sv - pixel stream bundle (tvalid/tready/tdata/tlast/tuser)
interface fifo_axis_drain_if import sr_pix_pkg::*; #(
  parameter int DATA_WIDTH = PIX_WIDTH
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);

endinterface

// File: rtl/pix_buf2.sv
// rtl/pix_buf2.sv - 2-entry in-order pixel buffer with simultaneous push/pop
module pix_buf2 import sr_pix_pkg::*; #(
  parameter int WIDTH = PIX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic [1:0]       wr_idx;

  // Slot the pushed word lands in once the pop shift has been applied
  always_comb begin
    wr_idx = cnt - {1'b0, pop};
  end

  // Head shifts on pop; an incoming word goes behind whatever remains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else begin
      if (pop) begin
        ent0 <= ent1;
      end
      if (push) begin
        if (wr_idx == 2'd0) begin
          ent0 <= push_data;
        end else begin
          ent1 <= push_data;
        end
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = ent0;

endmodule

// File: rtl/fifo_axis_drain.sv
// rtl/fifo_axis_drain.sv - BRAM FIFO reader to pixel stream master; FIFO_AXIS_DRAIN_STAT_EN adds stall/starve counters
module fifo_axis_drain #(
  parameter int DATA_WIDTH   = sr_pix_pkg::PIX_WIDTH,
  parameter int LINE_WIDTH   = sr_pix_pkg::LINE_WIDTH,
  parameter int FRAME_HEIGHT = sr_pix_pkg::FRAME_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_odata,
  fifo_axis_drain_if.master     m_axis
`ifdef FIFO_AXIS_DRAIN_STAT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           starve_cnt
`endif
);

  localparam int COL_W = sr_pix_pkg::cnt_width(LINE_WIDTH);
  localparam int ROW_W = sr_pix_pkg::cnt_width(FRAME_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);

  logic             inflight;
  logic [1:0]       cnt;
  logic             pop;
  logic [1:0]       occ_after;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign pop       = m_axis.tvalid & m_axis.tready;
  // Occupancy after this cycle's pop, counting the read already in flight
  assign occ_after = cnt + {1'b0, inflight} - {1'b0, pop};
  // Held low during reset so no read is lost while the buffer is being cleared
  assign fifo_rd   = rst_n & ~fifo_empty & (occ_after < 2'd2);

  // A read issued this cycle returns data next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd;
    end
  end

  pix_buf2 #(.WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_odata),
    .pop       (pop),
    .head      (m_axis.tdata),
    .cnt       (cnt)
  );

  assign m_axis.tvalid = (cnt != 2'd0);

  // Column/row position of the head beat, advanced only when a beat leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign m_axis.tlast = (col == COL_LAST);
  assign m_axis.tuser = (col == '0) && (row == '0);

`ifdef FIFO_AXIS_DRAIN_STAT_EN
  // Saturating counts of downstream stalls and mid-frame FIFO underruns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (m_axis.tvalid && !m_axis.tready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (!m_axis.tvalid && m_axis.tready && !m_axis.tuser && (starve_cnt != '1)) begin
        starve_cnt <= starve_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_axis_drain.sv
// tb/tb_fifo_axis_drain.sv - scoreboard bench for fifo_axis_drain; define FIFO_AXIS_DRAIN_STAT_EN to cover the counters
`timescale 1ns/1ps
module tb_fifo_axis_drain;
  import sr_pix_pkg::*;

  localparam int LW = 520;
  localparam int FH = 3;
  localparam int DW = PIX_WIDTH;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd;
  logic [DW-1:0] fifo_odata = '0;
`ifdef FIFO_AXIS_DRAIN_STAT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   starve_cnt;
`endif

  fifo_axis_drain_if #(.DATA_WIDTH(DW)) m_axis ();

  fifo_axis_drain #(
    .DATA_WIDTH   (DW),
    .LINE_WIDTH   (LW),
    .FRAME_HEIGHT (FH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_odata (fifo_odata),
    .m_axis     (m_axis)
`ifdef FIFO_AXIS_DRAIN_STAT_EN
    ,
    .stall_cnt  (stall_cnt),
    .starve_cnt (starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            pc = 0;
  int            pr = 0;
  logic          rd_prev = 1'b0;
  logic          rel_pending = 1'b0;
  int            beats = 0;
  int            n_last = 0;
  int            n_user = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected sideband follows the bench's own line/frame position
  task automatic expect_pix(input logic [DW-1:0] d);
    exp_q.push_back('{data: d, last: (pc == LW - 1), user: (pc == 0 && pr == 0)});
    if (pc == LW - 1) begin
      pc = 0;
      pr = (pr == FH - 1) ? 0 : pr + 1;
    end else begin
      pc++;
    end
  endtask

  task automatic push_n(input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = DW'($urandom);
      fifo_q.push_back(d);
      expect_pix(d);
    end
  endtask

  // Buffered/in-flight words are lost; words still in the FIFO restart at (0,0)
  task automatic assert_reset();
    rst_n = 1'b0;
    rd_prev = 1'b0;
    exp_q.delete();
    pc = 0;
    pr = 0;
    foreach (fifo_q[i]) expect_pix(fifo_q[i]);
    rel_pending = 1'b1;
  endtask

  task automatic do_reset();
    assert_reset();
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rd"}, 64'(fifo_rd), 64'd0);
    check({pfx, "_tvalid"}, 64'(m_axis.tvalid), 64'd0);
    check({pfx, "_tdata"}, 64'(m_axis.tdata), 64'd0);
    check({pfx, "_tlast"}, 64'(m_axis.tlast), 64'd0);
    check({pfx, "_tuser"}, 64'(m_axis.tuser), 64'd1);
  endtask

  // One clock: FIFO model answers last read, drive tready, score any beat
  task automatic cycle(input logic rdy);
    exp_t e;
    @(negedge clk);
    if (rd_prev && fifo_q.size() != 0) fifo_odata = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    m_axis.tready = rdy;
    if (rel_pending) begin
      rst_n = 1'b1;
      rel_pending = 1'b0;
    end
    #1;
    check("rd_when_empty", 64'(fifo_rd & fifo_empty), 64'd0);
    rd_prev = fifo_rd;
    if (m_axis.tvalid && m_axis.tready) begin
      beats++;
      if (m_axis.tlast) n_last++;
      if (m_axis.tuser) n_user++;
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tdata", 64'(m_axis.tdata), 64'(e.data));
        check("tlast", 64'(m_axis.tlast), 64'(e.last));
        check("tuser", 64'(m_axis.tuser), 64'(e.user));
      end
    end
  endtask

  task automatic drain(input bit rand_rdy, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      cycle(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] first;
    int rds, b0, l0, u0, n;

    m_axis.tready = 1'b0;
    assert_reset();
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);

    // Four preloaded pixels with tready high
    push_n(4);
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1);
      check("t1_rd", 64'(fifo_rd), 64'(c < 4));
      check("t1_tvalid", 64'(m_axis.tvalid), 64'(c >= 2 && c < 6));
    end
    check("t1_beats", 64'(beats), 64'd4);
    check("t1_users", 64'(n_user), 64'd1);

    // Ten pixels with tready held low, then released
    push_n(10);
    first = exp_q[0].data;
    rds = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0);
      if (fifo_rd) rds++;
      if (c >= 2) check("t2_hold_tdata", 64'(m_axis.tdata), 64'(first));
    end
    check("t2_reads", 64'(rds), 64'd2);
    check("t2_tvalid", 64'(m_axis.tvalid), 64'd1);
    check("t2_fifo_left", 64'(fifo_q.size()), 64'd8);
    b0 = beats;
    for (int c = 0; c < 10; c++) cycle(1'b1);
    check("t2_no_gap", 64'(beats - b0), 64'd10);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Full frame plus two beats of the next, random tready
    do_reset();
    l0 = n_last;
    u0 = n_user;
    push_n(LW * FH + 2);
    drain(1'b1, 20 * (LW * FH + 2));
    check("t3_lasts", 64'(n_last - l0), 64'(FH));
    check("t3_users", 64'(n_user - u0), 64'd2);

    // FIFO runs dry at column 500 for seven cycles
    do_reset();
    push_n(500);
    drain(1'b0, 2000);
    for (int c = 0; c < 7; c++) begin
      cycle(1'b1);
      check("t4_gap_tvalid", 64'(m_axis.tvalid), 64'd0);
    end
    l0 = n_last;
    push_n(30);
    drain(1'b0, 200);
    check("t4_lasts", 64'(n_last - l0), 64'd1);

    // Reset mid-line while the buffer holds a beat and a read is in flight
    do_reset();
    push_n(20);
    repeat (5) cycle(1'b1);
    #2;
    assert_reset();
    #1;
    check_reset_outputs("t5");
    u0 = n_user;
    repeat (2) @(posedge clk);
    drain(1'b0, 200);
    check("t5_users", 64'(n_user - u0), 64'd1);

`ifdef FIFO_AXIS_DRAIN_STAT_EN
    // Five stalled cycles, then a three-cycle underrun at column 2
    do_reset();
    push_n(2);
    n = 0;
    while (!m_axis.tvalid && n < 10) begin
      cycle(1'b0);
      n++;
    end
    check("t6_tvalid", 64'(m_axis.tvalid), 64'd1);
    repeat (4) cycle(1'b0);
    cycle(1'b1);
    check("t6_stall", 64'(stall_cnt), 64'd5);
    check("t6_starve0", 64'(starve_cnt), 64'd0);
    n = 0;
    while (m_axis.tvalid && n < 10) begin
      cycle(1'b1);
      n++;
    end
    repeat (2) cycle(1'b1);
    cycle(1'b0);
    check("t6_starve", 64'(starve_cnt), 64'd3);
    check("t6_stall_hold", 64'(stall_cnt), 64'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
